// File: rtl/counter_cmd_seq.sv
// Command sequencer driving the control pins of a 16-bit up/down counter.
// Optional `CMD_SEQ_ABORT_EN adds an abort input that cuts a count run short.
module counter_cmd_seq #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
`ifdef CMD_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] data_in,
  output logic             ld_cnt,
  output logic             updn_cnt,
  output logic             count_enb,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_UP   = 2'b10;
  localparam logic [1:0] OP_DN   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             ld;
    logic             updn;
    logic             enb;
    logic             busy;
    logic             done;
  } ctl_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] run_q, run_d;
  ctl_t             ctl_q, ctl_d;
  logic [LEN_W-1:0] cmd_len;
  logic             abort_hit;

`ifdef CMD_SEQ_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign cmd_len   = cmd_arg[LEN_W-1:0];
  assign cmd_ready = (state_q == S_IDLE);

  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    ctl_d        = '0;
    ctl_d.ld     = 1'b1;
    ctl_d.updn   = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_LOAD: begin
              state_d    = S_LOAD;
              ctl_d.ld   = 1'b0;
              ctl_d.data = cmd_arg;
            end
            OP_UP, OP_DN: begin
              // zero-length runs retire immediately like a NOP
              if (cmd_len != '0) begin
                state_d    = S_RUN;
                run_d      = cmd_len - LEN_W'(1);
                ctl_d.enb  = 1'b1;
                ctl_d.updn = (cmd_op == OP_UP);
              end else begin
                ctl_d.done = 1'b1;
              end
            end
            OP_NOP:  ctl_d.done = 1'b1;
            default: ctl_d.done = 1'b1;
          endcase
        end
      end
      S_LOAD: begin
        state_d    = S_IDLE;
        ctl_d.done = 1'b1;
      end
      S_RUN: begin
        if (abort_hit || run_q == '0) begin
          state_d    = S_IDLE;
          ctl_d.done = 1'b1;
        end else begin
          run_d      = run_q - LEN_W'(1);
          ctl_d.enb  = 1'b1;
          ctl_d.updn = ctl_q.updn;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ctl_d.busy = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q    <= S_IDLE;
      run_q      <= '0;
      ctl_q      <= '0;
      ctl_q.ld   <= 1'b1;
      ctl_q.updn <= 1'b1;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      ctl_q   <= ctl_d;
    end
  end

  assign data_in   = ctl_q.data;
  assign ld_cnt    = ctl_q.ld;
  assign updn_cnt  = ctl_q.updn;
  assign count_enb = ctl_q.enb;
  assign busy      = ctl_q.busy;
  assign done      = ctl_q.done;

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Bench for counter_cmd_seq: vector table, directed corner sequences and a
// queue-based schedule model under random stimulus; tracks an attached counter.
module tb_counter_cmd_seq;
  localparam int WIDTH = 16;
  localparam int LEN_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_, cmd_valid, abort;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_arg;
  logic             cmd_ready, ld_cnt, updn_cnt, count_enb, busy, done;
  logic [WIDTH-1:0] data_in;

  counter_cmd_seq #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_(rst_), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg),
`ifdef CMD_SEQ_ABORT_EN
    .abort(abort),
`endif
    .data_in(data_in), .ld_cnt(ld_cnt), .updn_cnt(updn_cnt),
    .count_enb(count_enb), .busy(busy), .done(done)
  );

  // attached up/down counter, driven by the sequencer's pins
  logic [WIDTH-1:0] cnt = '0;
  always @(posedge clk) begin
    if (!ld_cnt)        cnt <= data_in;
    else if (count_enb) cnt <= updn_cnt ? cnt + 1'b1 : cnt - 1'b1;
  end

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic ld, updn, enb, bsy, dn, rdy;
  } obs_t;

  function automatic obs_t mk(input logic [WIDTH-1:0] d, input logic ld, updn, enb, bsy, dn, rdy);
    mk = {d, ld, updn, enb, bsy, dn, rdy};
  endfunction
  function automatic obs_t o_idle();  return mk('0, 1, 1, 0, 0, 0, 1); endfunction
  function automatic obs_t o_done();  return mk('0, 1, 1, 0, 0, 1, 1); endfunction
  function automatic obs_t o_load(input logic [WIDTH-1:0] a); return mk(a, 0, 1, 0, 1, 0, 0); endfunction
  function automatic obs_t o_run(input logic up); return mk('0, 1, up, 1, 1, 0, 0); endfunction
  function automatic obs_t observe();
    return {data_in, ld_cnt, updn_cnt, count_enb, busy, done, cmd_ready};
  endfunction

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one handshake, then run until done or a cycle budget expires
  task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] arg,
                       output int enbc, output int upc, output int ldc,
                       output logic [WIDTH-1:0] ldval, output logic got_done);
    enbc = 0; upc = 0; ldc = 0; ldval = '0; got_done = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    tick();
    cmd_valid = 1'b0;
    for (int c = 0; c < 300 && !got_done; c++) begin
      if (count_enb) enbc++;
      if (count_enb && updn_cnt) upc++;
      if (!ld_cnt) begin ldc++; ldval = data_in; end
      if (done) got_done = 1'b1;
      else tick();
    end
  endtask

  typedef struct {
    logic rst, valid;
    logic [1:0] op;
    logic [WIDTH-1:0] arg;
    obs_t exp;
  } vec_t;
  vec_t vt[16];

  obs_t exp_o;
  obs_t sched[$];

  initial begin
    int enbc, upc, ldc;
    logic [WIDTH-1:0] ldval, c0;
    logic got_done;
    logic [7:0] rdy_pat;
    int acc, L;

    rst_ = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = '0; abort = 1'b0;

    vt[0]  = '{1, 1, 2'b10, 16'd5,     o_idle()};
    vt[1]  = '{1, 1, 2'b10, 16'd5,     o_idle()};
    vt[2]  = '{1, 1, 2'b10, 16'd5,     o_idle()};
    vt[3]  = '{0, 1, 2'b01, 16'd6942,  o_load(16'd6942)};
    vt[4]  = '{0, 0, 2'b00, 16'd0,     o_done()};
    vt[5]  = '{0, 0, 2'b00, 16'd0,     o_idle()};
    vt[6]  = '{0, 1, 2'b11, 16'd0,     o_done()};
    vt[7]  = '{0, 1, 2'b11, 16'hFF00,  o_done()};
    vt[8]  = '{0, 1, 2'b00, 16'd0,     o_done()};
    vt[9]  = '{0, 0, 2'b00, 16'd0,     o_idle()};
    vt[10] = '{0, 1, 2'b10, 16'd2,     o_run(1)};
    vt[11] = '{0, 1, 2'b11, 16'd9,     o_run(1)};
    vt[12] = '{0, 1, 2'b11, 16'd9,     o_done()};
    vt[13] = '{0, 1, 2'b11, 16'd1,     o_run(0)};
    vt[14] = '{0, 0, 2'b00, 16'd0,     o_done()};
    vt[15] = '{0, 0, 2'b00, 16'd0,     o_idle()};

    foreach (vt[i]) begin
      rst_ = vt[i].rst; cmd_valid = vt[i].valid; cmd_op = vt[i].op; cmd_arg = vt[i].arg;
      tick();
      chk($sformatf("vec%0d", i), 64'(observe()), 64'(vt[i].exp));
    end
    cmd_valid = 1'b0;
    chk("vec_counter", 64'(cnt), 64'd6943);

    // load then up 5 then down 7
    issue(2'b01, 16'd6942, enbc, upc, ldc, ldval, got_done);
    chk("load_done", 64'(got_done), 64'd1);
    chk("load_ld_cycles", 64'(ldc), 64'd1);
    chk("load_value", 64'(ldval), 64'd6942);
    chk("load_counter", 64'(cnt), 64'd6942);
    issue(2'b10, 16'd5, enbc, upc, ldc, ldval, got_done);
    chk("up5_done", 64'(got_done), 64'd1);
    chk("up5_enb_cycles", 64'(enbc), 64'd5);
    chk("up5_up_cycles", 64'(upc), 64'd5);
    chk("up5_counter", 64'(cnt), 64'd6947);
    issue(2'b11, 16'd7, enbc, upc, ldc, ldval, got_done);
    chk("dn7_done", 64'(got_done), 64'd1);
    chk("dn7_enb_cycles", 64'(enbc), 64'd7);
    chk("dn7_up_cycles", 64'(upc), 64'd0);
    chk("dn7_counter", 64'(cnt), 64'd6940);
    issue(2'b10, 16'h0100, enbc, upc, ldc, ldval, got_done);
    chk("len0_enb_cycles", 64'(enbc), 64'd0);
    issue(2'b10, 16'd255, enbc, upc, ldc, ldval, got_done);
    chk("len_max_enb_cycles", 64'(enbc), 64'd255);

    // reset in the third RUN cycle of a 10-long run
    tick();
    c0 = cnt;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_arg = 16'd10;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("rst_mid_run_pre", 64'(observe()), 64'(o_run(1)));
    rst_ = 1'b1;
    tick();
    rst_ = 1'b0;
    chk("rst_mid_run_out", 64'(observe()), 64'(o_idle()));
    chk("rst_mid_run_counter", 64'(cnt), 64'(c0 + 16'd3));
    tick();
    chk("rst_mid_run_nodone", 64'(done), 64'd0);

    // valid held high: accepted once, then again in the done cycle
    acc = 0;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_arg = 16'd3;
    for (int c = 0; c < 8; c++) begin
      rdy_pat[c] = cmd_ready;
      if (cmd_ready) acc++;
      tick();
    end
    cmd_valid = 1'b0;
    chk("held_ready_pattern", 64'(rdy_pat), 64'h11);
    chk("held_accepts", 64'(acc), 64'd2);
    chk("held_second_done", 64'(observe()), 64'(o_done()));
    tick();

`ifdef CMD_SEQ_ABORT_EN
    c0 = cnt;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_arg = 16'd10;
    tick();
    cmd_valid = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_out", 64'(observe()), 64'(o_done()));
    chk("abort_counter", 64'(cnt), 64'(c0 + 16'd2));
    tick();
    abort = 1'b1;
    issue(2'b01, 16'd77, enbc, upc, ldc, ldval, got_done);
    abort = 1'b0;
    chk("abort_in_load_ignored", 64'(ldc), 64'd1);
`endif

    // random phase against the schedule model
    rst_ = 1'b1; cmd_valid = 1'b0;
    tick();
    rst_ = 1'b0;
    exp_o = o_idle();
    sched.delete();
    for (int i = 0; i < 800; i++) begin
      rst_      = ($urandom_range(0, 49) == 0);
      cmd_valid = $urandom_range(0, 1) != 0;
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_arg   = WIDTH'($urandom);
      if (cmd_op[1]) cmd_arg[LEN_W-1:0] = LEN_W'($urandom_range(0, 6));
`ifdef CMD_SEQ_ABORT_EN
      abort = ($urandom_range(0, 7) == 0);
`endif
      @(posedge clk);
      if (rst_) begin
        sched.delete();
        exp_o = o_idle();
      end else if (abort && exp_o.enb) begin
        sched.delete();
        exp_o = o_done();
      end else if (cmd_valid && exp_o.rdy) begin
        sched.delete();
        L = (cmd_op[1]) ? int'(cmd_arg[LEN_W-1:0]) : 0;
        if (cmd_op == 2'b01) sched.push_back(o_load(cmd_arg));
        for (int j = 0; j < L; j++) sched.push_back(o_run(cmd_op == 2'b10));
        sched.push_back(o_done());
        exp_o = sched.pop_front();
      end else if (sched.size() != 0) begin
        exp_o = sched.pop_front();
      end else begin
        exp_o = o_idle();
      end
      #1;
      chk($sformatf("rand%0d", i), 64'(observe()), 64'(exp_o));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
